daq_conv_sched: RTL

- Sequencer that paces ADC conversions for the DAQ path. It drives the AD7606-style CONVST/BUSY handshake and applies the oversampling select to the ADC.
- After each conversion it hands the read of the sample set to daqpacketizer through a request/done handshake.
- It reports overruns and ADC timeouts. It sits between the host-configured registers and daqpacketizer.

---
 rtl/daq_conv_sched_if.sv | 29 ++
 rtl/daq_conv_sched.sv | 139 +++++++++++++
 2 files changed

// File: rtl/daq_conv_sched_if.sv
// Signal bundle between daq_conv_sched, the host registers, the ADC and daqpacketizer.
// master is the scheduler side, slave is the environment around it.
interface daq_conv_sched_if #(
   parameter int PERIOD_W = 16
);
   logic                enable_i;
   logic [2:0]          os_sel_i;
   logic [PERIOD_W-1:0] period_i;
   logic                adc_busy_i;
   logic                pkt_done_i;
   logic                clr_err_i;
   logic                adc_convst_o;
   logic [2:0]          adc_os_o;
   logic                pkt_req_o;
   logic                overrun_o;
   logic                timeout_o;
   logic [31:0]         sample_cnt_o;
   logic                busy_o;

   modport master (
      input  enable_i, os_sel_i, period_i, adc_busy_i, pkt_done_i, clr_err_i,
      output adc_convst_o, adc_os_o, pkt_req_o, overrun_o, timeout_o, sample_cnt_o, busy_o
   );

   modport slave (
      output enable_i, os_sel_i, period_i, adc_busy_i, pkt_done_i, clr_err_i,
      input  adc_convst_o, adc_os_o, pkt_req_o, overrun_o, timeout_o, sample_cnt_o, busy_o
   );
endinterface

// File: rtl/daq_conv_sched.sv
// Paces ADC conversions (CONVST/BUSY handshake) and hands each sample set to daqpacketizer.
//
// state       | meaning
// S_IDLE      | waiting for a period tick; adc_os_o tracks os_sel_i
// S_CONV      | CONVST held low for CONVST_LOW cycles
// S_WAIT_RISE | CONVST released, waiting up to BUSY_RISE_MAX cycles for BUSY high
// S_WAIT_FALL | conversion running, waiting up to BUSY_TIMEOUT cycles for BUSY low
// S_READ      | pkt_req_o high until daqpacketizer pulses pkt_done_i
module daq_conv_sched #(
   parameter int PERIOD_W      = 16,
   parameter int CONVST_LOW    = 4,
   parameter int BUSY_RISE_MAX = 16,
   parameter int BUSY_TIMEOUT  = 8192
) (
   input logic                clk_i,
   input logic                reset_n_i,
   daq_conv_sched_if.master   bus
);
   localparam int TMR_W = $clog2(BUSY_TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CONV,
      S_WAIT_RISE,
      S_WAIT_FALL,
      S_READ
   } state_t;

   state_t              state_q, state_d;
   logic [TMR_W-1:0]    tmr_q, tmr_d;
   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic [PERIOD_W-1:0] per_q, per_d;
   logic [PERIOD_W-1:0] per_in, per_eff;
   logic [2:0]          os_q, os_d;
   logic                ovr_q, ovr_d;
   logic                to_q, to_d;
   logic [31:0]         smp_q, smp_d;
   logic                tick;
   logic                to_set;

   // The period is sampled on the first cycle of each period, so a mid-period write waits for the wrap.
   always_comb begin
      per_in  = (bus.period_i < PERIOD_W'(2)) ? PERIOD_W'(2) : bus.period_i;
      per_eff = (cnt_q == '0) ? per_in : per_q;
      per_d   = per_eff;
      tick    = bus.enable_i && (cnt_q == per_eff - PERIOD_W'(1));
      if (!bus.enable_i || tick) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + PERIOD_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      smp_d   = smp_q;
      to_set  = 1'b0;
      os_d    = (state_q == S_IDLE) ? bus.os_sel_i : os_q;
      case (state_q)
         S_IDLE: begin
            if (tick) begin
               state_d = S_CONV;
               tmr_d   = TMR_W'(CONVST_LOW - 1);
            end
         end
         S_CONV: begin
            if (tmr_q == '0) begin
               state_d = S_WAIT_RISE;
               tmr_d   = TMR_W'(BUSY_RISE_MAX - 1);
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         S_WAIT_RISE: begin
            if (bus.adc_busy_i) begin
               state_d = S_WAIT_FALL;
               tmr_d   = TMR_W'(BUSY_TIMEOUT - 1);
            end else if (tmr_q == '0) begin
               state_d = S_IDLE;
               to_set  = 1'b1;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         S_WAIT_FALL: begin
            if (!bus.adc_busy_i) begin
               state_d = S_READ;
            end else if (tmr_q == '0) begin
               state_d = S_IDLE;
               to_set  = 1'b1;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         S_READ: begin
            if (bus.pkt_done_i) begin
               state_d = S_IDLE;
               smp_d   = smp_q + 32'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A set event outranks a simultaneous clear.
      ovr_d = (tick && (state_q != S_IDLE)) ? 1'b1 : (bus.clr_err_i ? 1'b0 : ovr_q);
      to_d  = to_set ? 1'b1 : (bus.clr_err_i ? 1'b0 : to_q);
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= S_IDLE;
         tmr_q   <= '0;
         cnt_q   <= '0;
         per_q   <= PERIOD_W'(2);
         os_q    <= '0;
         ovr_q   <= 1'b0;
         to_q    <= 1'b0;
         smp_q   <= '0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         cnt_q   <= cnt_d;
         per_q   <= per_d;
         os_q    <= os_d;
         ovr_q   <= ovr_d;
         to_q    <= to_d;
         smp_q   <= smp_d;
      end
   end

   assign bus.adc_convst_o = (state_q != S_CONV);
   assign bus.adc_os_o     = os_q;
   assign bus.pkt_req_o    = (state_q == S_READ);
   assign bus.overrun_o    = ovr_q;
   assign bus.timeout_o    = to_q;
   assign bus.sample_cnt_o = smp_q;
   assign bus.busy_o       = (state_q != S_IDLE);
endmodule
